// File: rtl/mux_nx1_scan_pkg.sv
// Shared types and defaults for the N:1 scanning multiplexer (package mux_pkg).
package mux_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    localparam int N_DEFAULT     = 16;
    localparam int W_DEFAULT     = 1;
    localparam int DWELL_DEFAULT = 4;

endpackage

// File: rtl/mux_nx1_scan_comb.sv
// Purely combinational N:1 channel selector; an out-of-range select yields zero.
module mux_nx1_comb #(
    parameter int N  = 16,
    parameter int W  = 1,
    parameter int SW = $clog2(N)
) (
    input  logic [N*W-1:0] in,
    input  logic [SW-1:0]  sel,
    output logic [W-1:0]   out
);

    always_comb begin
        out = '0;
        for (int k = 0; k < N; k++) begin
            if (int'(sel) == k) begin
                out = in[k*W +: W];
            end
        end
    end

endmodule

// File: rtl/mux_nx1_scan.sv
// N:1 mux with direct select and timed scan modes behind a one-deep valid/ready output slot.
// Optional parity output enabled by defining MUX_NX1_SCAN_PARITY_EN.
module mux_nx1_scan
    import mux_pkg::*;
#(
    parameter int N     = N_DEFAULT,
    parameter int W     = W_DEFAULT,
    parameter int DWELL = DWELL_DEFAULT,
    localparam int SW   = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N*W-1:0] in,
    input  logic [SW-1:0]  sel,
    input  logic           mode,
    input  logic           start,
    input  logic           out_ready,
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_sel,
    output logic           out_valid,
`ifdef MUX_NX1_SCAN_PARITY_EN
    output logic           out_par,
`endif
    output logic           busy
);

    localparam logic [7:0]    DWELL_LAST = 8'(DWELL - 1);
    localparam logic [SW-1:0] CH_LAST    = SW'(N - 1);

    state_t        state_q, state_d;
    logic [SW-1:0] ch_q, ch_d;
    logic [7:0]    dwell_q, dwell_d;
    logic [W-1:0]  data_q, data_d;
    logic [SW-1:0] osel_q, osel_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic          slot_free;
    logic          capture;
    logic [SW-1:0] mux_sel;
    logic [W-1:0]  mux_out;

    // The scan counter owns the selector while scanning, the sel port otherwise.
    assign mux_sel   = (state_q == SCAN) ? ch_q : sel;
    assign slot_free = !valid_q || out_ready;

    mux_nx1_comb #(
        .N  (N),
        .W  (W),
        .SW (SW)
    ) u_sel (
        .in  (in),
        .sel (mux_sel),
        .out (mux_out)
    );

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        dwell_d = dwell_q;
        data_d  = data_q;
        osel_d  = osel_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        capture = 1'b0;

        if (out_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (mode == MODE_DIRECT) begin
                    capture = slot_free;
                end else if (start) begin
                    state_d = SCAN;
                    busy_d  = 1'b1;
                    ch_d    = '0;
                    dwell_d = '0;
                end
            end
            SCAN: begin
                if (dwell_q != DWELL_LAST) begin
                    dwell_d = dwell_q + 8'd1;
                end else if (slot_free) begin
                    // Counters only move on a successful capture, so a stall loses nothing.
                    capture = 1'b1;
                    dwell_d = '0;
                    if (ch_q == CH_LAST) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        ch_d    = '0;
                    end else begin
                        ch_d = ch_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (capture) begin
            data_d  = mux_out;
            osel_d  = mux_sel;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ch_q    <= '0;
            dwell_q <= '0;
            data_q  <= '0;
            osel_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            dwell_q <= dwell_d;
            data_q  <= data_d;
            osel_q  <= osel_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign out_data  = data_q;
    assign out_sel   = osel_q;
    assign out_valid = valid_q;
    assign busy      = busy_q;

`ifdef MUX_NX1_SCAN_PARITY_EN
    logic par_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_q <= 1'b0;
        end else begin
            par_q <= ^data_d;
        end
    end

    assign out_par = par_q;
`endif

endmodule

// File: tb/tb_mux_nx1_scan.sv
// Directed self-checking bench for mux_nx1_scan: direct mode, backpressure, scan, stall, reset.
// Parity checks are compiled in when MUX_NX1_SCAN_PARITY_EN is defined.
module tb_mux_nx1_scan;

    localparam int N     = 16;
    localparam int W     = 1;
    localparam int DWELL = 4;
    localparam int SW    = $clog2(N);

    logic           clk = 1'b0;
    logic           rst;
    logic [N*W-1:0] in;
    logic [SW-1:0]  sel;
    logic           mode;
    logic           start;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_sel;
    logic           out_valid;
    logic           busy;

    int checks = 0;
    int errors = 0;
    int captures = 0;

    always #5 clk = ~clk;

    mux_nx1_scan #(
        .N     (N),
        .W     (W),
        .DWELL (DWELL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in),
        .sel       (sel),
        .mode      (mode),
        .start     (start),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
`ifdef MUX_NX1_SCAN_PARITY_EN
        .out_par   (),
`endif
        .busy      (busy)
    );

`ifdef MUX_NX1_SCAN_PARITY_EN
    logic [15:0] p_in;
    logic [1:0]  p_sel;
    logic [3:0]  p_data;
    logic [1:0]  p_osel;
    logic        p_valid;
    logic        p_par;
    logic        p_busy;

    mux_nx1_scan #(
        .N     (4),
        .W     (4),
        .DWELL (2)
    ) dut_par (
        .clk       (clk),
        .rst       (rst),
        .in        (p_in),
        .sel       (p_sel),
        .mode      (1'b0),
        .start     (1'b0),
        .out_ready (1'b1),
        .out_data  (p_data),
        .out_sel   (p_osel),
        .out_valid (p_valid),
        .out_par   (p_par),
        .busy      (p_busy)
    );
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Three quiet dwell cycles, then the capture of channel k from in=16'hAAAA.
    task automatic scan_capture(input int k);
        for (int d = 1; d < DWELL; d++) begin
            step();
            chk("scan_gap_valid", 32'(out_valid), 32'd0);
        end
        step();
        chk("scan_cap_valid", 32'(out_valid), 32'd1);
        chk("scan_cap_sel", 32'(out_sel), 32'(k));
        chk("scan_cap_data", 32'(out_data), 32'(k & 1));
        if (out_valid) captures++;
    endtask

    initial begin
        rst = 1'b1;
        in = '0;
        sel = '0;
        mode = 1'b0;
        start = 1'b0;
        out_ready = 1'b0;
`ifdef MUX_NX1_SCAN_PARITY_EN
        p_in = {4'h0, 4'h0, 4'b0110, 4'b0111};
        p_sel = 2'd0;
`endif
        step();
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_sel", 32'(out_sel), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // Direct mode
        rst = 1'b0;
        mode = 1'b0;
        out_ready = 1'b1;
        in = 16'h8001;
        sel = 4'd0;
        step();
        chk("dir0_data", 32'(out_data), 32'd1);
        chk("dir0_sel", 32'(out_sel), 32'd0);
        chk("dir0_valid", 32'(out_valid), 32'd1);
        sel = 4'd15;
        step();
        chk("dir15_data", 32'(out_data), 32'd1);
        chk("dir15_sel", 32'(out_sel), 32'd15);
        sel = 4'd1;
        step();
        chk("dir1_data", 32'(out_data), 32'd0);
        chk("dir1_sel", 32'(out_sel), 32'd1);

        // Direct-mode backpressure
        in = 16'h0004;
        sel = 4'd2;
        step();
        chk("bp_first_data", 32'(out_data), 32'd1);
        chk("bp_first_sel", 32'(out_sel), 32'd2);
        out_ready = 1'b0;
        sel = 4'd3;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold_data", 32'(out_data), 32'd1);
            chk("bp_hold_sel", 32'(out_sel), 32'd2);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        step();
        chk("bp_release_sel", 32'(out_sel), 32'd3);
        chk("bp_release_data", 32'(out_data), 32'd0);
        chk("bp_release_valid", 32'(out_valid), 32'd1);

        // Scan mode selected without start: accept drains, nothing captured
        mode = 1'b1;
        start = 1'b0;
        step();
        chk("idle_scan_valid", 32'(out_valid), 32'd0);
        step();
        chk("idle_scan_busy", 32'(busy), 32'd0);

        // Full scan, with a mode flip in the middle that must be ignored
        in = 16'hAAAA;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("scan_busy_start", 32'(busy), 32'd1);
        chk("scan_start_valid", 32'(out_valid), 32'd0);
        captures = 0;
        for (int k = 0; k < N; k++) begin
            mode = (k >= 3 && k <= 8) ? 1'b0 : 1'b1;
            scan_capture(k);
            chk("scan_busy", 32'(busy), (k == N - 1) ? 32'd0 : 32'd1);
        end
        chk("scan_count", 32'(captures), 32'd16);
        step();
        chk("scan_done_valid", 32'(out_valid), 32'd0);

        // Scan with a 10-cycle stall at channel 5
        start = 1'b1;
        step();
        start = 1'b0;
        captures = 0;
        for (int k = 0; k <= 5; k++) scan_capture(k);
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("stall_hold_sel", 32'(out_sel), 32'd5);
            chk("stall_hold_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        step();
        chk("stall_ch6_sel", 32'(out_sel), 32'd6);
        chk("stall_ch6_valid", 32'(out_valid), 32'd1);
        if (out_valid) captures++;
        for (int k = 7; k < N; k++) scan_capture(k);
        chk("stall_count", 32'(captures), 32'd16);
        chk("stall_busy_end", 32'(busy), 32'd0);

        // Reset in the middle of a scan
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k <= 7; k++) scan_capture(k);
        #2;
        rst = 1'b1;
        #1;
        chk("mrst_data", 32'(out_data), 32'd0);
        chk("mrst_sel", 32'(out_sel), 32'd0);
        chk("mrst_valid", 32'(out_valid), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("mrst_quiet_valid", 32'(out_valid), 32'd0);
            chk("mrst_quiet_busy", 32'(busy), 32'd0);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        chk("rescan_busy", 32'(busy), 32'd1);
        scan_capture(0);
        scan_capture(1);

`ifdef MUX_NX1_SCAN_PARITY_EN
        p_sel = 2'd0;
        step();
        chk("par_0111_data", 32'(p_data), 32'h7);
        chk("par_0111", 32'(p_par), 32'd1);
        p_sel = 2'd1;
        step();
        chk("par_0110_data", 32'(p_data), 32'h6);
        chk("par_0110", 32'(p_par), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
